output_commutator: RTL and testbench

Parametrised delay-commutator stage for the FFT output path. It takes two parallel sample lines and delays the second line by DEPTH accepted samples. A swap switch, driven by an internal sample counter, pairs samples across the lines, and a matching DEPTH-sample delay on the upper branch realigns the result. The stage sits between the last butterfly and the output reorder logic, one instance per commutator level, with DEPTH halving from level to level. It supports valid-qualified streaming with stalls and a synchronous frame restart.

---
 rtl/output_commutator_if.sv | 44 ++++
 rtl/output_commutator.sv | 142 ++++++++++++++
 tb/tb_output_commutator.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/output_commutator_if.sv
// Sample-stream bundle for one delay-commutator stage.
// Optional feature macro: OUTCOMM_EXT_SEL_EN adds the external switch select sel_in.
// The master drives samples and frame control; the slave (the commutator) returns
// the registered output pair.
interface output_commutator_if #(
    parameter int WIDTH = 12
);
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] line1;
    logic [WIDTH-1:0] line2;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_valid;
`ifdef OUTCOMM_EXT_SEL_EN
    logic             sel_in;
`endif

    modport master (
`ifdef OUTCOMM_EXT_SEL_EN
        output sel_in,
`endif
        output clr,
        output in_valid,
        output line1,
        output line2,
        input  out_a,
        input  out_b,
        input  out_valid
    );

    modport slave (
`ifdef OUTCOMM_EXT_SEL_EN
        input  sel_in,
`endif
        input  clr,
        input  in_valid,
        input  line1,
        input  line2,
        output out_a,
        output out_b,
        output out_valid
    );
endinterface

// File: rtl/output_commutator.sv
// Delay-commutator stage for the FFT output path.
// line2 is delayed by DEPTH accepted samples, a switch pairs samples across the two
// lines, and a matching DEPTH-sample delay on the upper branch realigns the pair.
// Optional feature macro: OUTCOMM_EXT_SEL_EN -- the switch follows bus.sel_in
// instead of the internal sample counter; fill, valid and clr are unaffected.
module output_commutator #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    output_commutator_if.slave  bus
);
    // cnt wraps naturally at 2*DEPTH because DEPTH is a power of two
    localparam int CW = $clog2(DEPTH) + 1;
    // fill must be able to hold the value 2*DEPTH itself
    localparam int FW = CW + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(2 * DEPTH);

    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] d1_old;
    logic [WIDTH-1:0] d2_old;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;

    logic [WIDTH-1:0] d1_q [DEPTH];
    logic [WIDTH-1:0] d1_d [DEPTH];
    logic [WIDTH-1:0] d2_q [DEPTH];
    logic [WIDTH-1:0] d2_d [DEPTH];

    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_a_d;
    logic [WIDTH-1:0] out_b_q;
    logic [WIDTH-1:0] out_b_d;
    logic             out_valid_q;
    logic             out_valid_d;

    // a sample presented together with clr is discarded
    assign accept = bus.in_valid & ~bus.clr;

    assign d1_old = d1_q[DEPTH-1];
    assign d2_old = d2_q[DEPTH-1];

`ifdef OUTCOMM_EXT_SEL_EN
    assign sel = bus.sel_in;
`else
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sel = cnt_q[CW-1];

    // sample counter: restarts on clr, advances once per accepted sample
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.in_valid) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // sample counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign upper = sel ? d2_old   : bus.line1;
    assign lower = sel ? bus.line1 : d2_old;

    // both delay lines shift only on an accepted sample; clr leaves their contents alone
    always_comb begin
        d1_d = d1_q;
        d2_d = d2_q;
        if (accept) begin
            d1_d[0] = upper;
            d2_d[0] = bus.line2;
            for (int i = 1; i < DEPTH; i++) begin
                d1_d[i] = d1_q[i-1];
                d2_d[i] = d2_q[i-1];
            end
        end
    end

    // delay-line storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                d1_q[i] <= '0;
                d2_q[i] <= '0;
            end
        end else begin
            d1_q <= d1_d;
            d2_q <= d2_d;
        end
    end

    // fill tracking and output pair: output is valid once both delay lines hold frame data
    always_comb begin
        fill_d      = fill_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = 1'b0;
        if (bus.clr) begin
            fill_d = '0;
        end else if (accept) begin
            out_a_d     = d1_old;
            out_b_d     = lower;
            out_valid_d = (fill_q == FILL_FULL);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // output and fill registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_output_commutator.sv
// Bench for output_commutator: one DEPTH=1 and one DEPTH=4 instance driven with the
// same stream, checked against a history-based reference model plus directed values.
module tb_output_commutator;
    localparam int W   = 12;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_commutator_if #(.WIDTH(W)) bus1 ();
    output_commutator_if #(.WIDTH(W)) bus4 ();

    output_commutator #(.WIDTH(W), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    output_commutator #(.WIDTH(W), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state, index 0 -> DEPTH=1, index 1 -> DEPTH=4
    int         dep [2] = '{1, 4};
    int         tot [2];
    int         ccnt[2];
    logic [W-1:0] l2h [2][HMAX];
    logic [W-1:0] uph [2][HMAX];
    logic [W-1:0] ea [2];
    logic [W-1:0] eb [2];
    logic         ev [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            tot[d]  = 0;
            ccnt[d] = 0;
            ea[d]   = '0;
            eb[d]   = '0;
            ev[d]   = 1'b0;
        end
    endfunction

    // line2 history gives d2, upper-branch history gives d1; frame position gives sel
    function automatic void model_step(int d, logic v, logic c, logic s,
                                       logic [W-1:0] l1, logic [W-1:0] l2);
        logic [W-1:0] d2v, d1v, up, lo;
        logic sel;
        int k;
        if (c) begin
            ccnt[d] = 0;
            ev[d]   = 1'b0;
        end else if (v) begin
            k   = tot[d];
            d2v = (k >= dep[d]) ? l2h[d][k-dep[d]] : '0;
`ifdef OUTCOMM_EXT_SEL_EN
            sel = s;
`else
            sel = ((ccnt[d] / dep[d]) % 2) == 1;
`endif
            up  = sel ? d2v : l1;
            lo  = sel ? l1 : d2v;
            d1v = (k >= dep[d]) ? uph[d][k-dep[d]] : '0;
            l2h[d][k] = l2;
            uph[d][k] = up;
            ea[d] = d1v;
            eb[d] = lo;
            ev[d] = (ccnt[d] >= 2 * dep[d]);
            tot[d]  = tot[d] + 1;
            ccnt[d] = ccnt[d] + 1;
        end else begin
            ev[d] = 1'b0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_d1_a"}, 32'(bus1.out_a), 32'(ea[0]));
        chk({tag, "_d1_b"}, 32'(bus1.out_b), 32'(eb[0]));
        chk({tag, "_d1_v"}, 32'(bus1.out_valid), 32'(ev[0]));
        chk({tag, "_d4_a"}, 32'(bus4.out_a), 32'(ea[1]));
        chk({tag, "_d4_b"}, 32'(bus4.out_b), 32'(eb[1]));
        chk({tag, "_d4_v"}, 32'(bus4.out_valid), 32'(ev[1]));
    endtask

    // called 1 time unit after a rising edge; returns 1 time unit after the next one
    task automatic step(input string tag, input logic v, input logic c, input logic s,
                        input logic [W-1:0] l1, input logic [W-1:0] l2);
        bus1.in_valid = v; bus1.clr = c; bus1.line1 = l1; bus1.line2 = l2;
        bus4.in_valid = v; bus4.clr = c; bus4.line1 = l1; bus4.line2 = l2;
`ifdef OUTCOMM_EXT_SEL_EN
        bus1.sel_in = s;
        bus4.sel_in = s;
`endif
        @(posedge clk);
        model_step(0, v, c, s, l1, l2);
        model_step(1, v, c, s, l1, l2);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [W-1:0] r1, r2;
        logic rv, rc, rs;

        rst = 1'b1;
        bus1.in_valid = 1'b0; bus1.clr = 1'b0; bus1.line1 = '0; bus1.line2 = '0;
        bus4.in_valid = 1'b0; bus4.clr = 1'b0; bus4.line1 = '0; bus4.line2 = '0;
`ifdef OUTCOMM_EXT_SEL_EN
        bus1.sel_in = 1'b0;
        bus4.sel_in = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("reset");

        // basic stream, DEPTH=1 directed values
        for (int k = 0; k < 5; k++) begin
            step("t1", 1'b1, 1'b0, 1'b0, W'(10 + k), W'(20 + k));
            if (k == 1) chk("t1_k1_valid", 32'(bus1.out_valid), 32'd0);
            if (k == 2) begin
                chk("t1_k2_valid", 32'(bus1.out_valid), 32'd1);
`ifdef OUTCOMM_EXT_SEL_EN
                chk("t1_k2_a", 32'(bus1.out_a), 32'd11);
                chk("t1_k2_b", 32'(bus1.out_b), 32'd21);
`else
                chk("t1_k2_a", 32'(bus1.out_a), 32'd20);
                chk("t1_k2_b", 32'(bus1.out_b), 32'd21);
`endif
            end
            if (k == 3) begin
`ifdef OUTCOMM_EXT_SEL_EN
                chk("t1_k3_a", 32'(bus1.out_a), 32'd12);
                chk("t1_k3_b", 32'(bus1.out_b), 32'd22);
`else
                chk("t1_k3_a", 32'(bus1.out_a), 32'd12);
                chk("t1_k3_b", 32'(bus1.out_b), 32'd13);
`endif
            end
            if (k == 4) begin
`ifdef OUTCOMM_EXT_SEL_EN
                chk("t1_k4_a", 32'(bus1.out_a), 32'd13);
                chk("t1_k4_b", 32'(bus1.out_b), 32'd23);
`else
                chk("t1_k4_a", 32'(bus1.out_a), 32'd22);
                chk("t1_k4_b", 32'(bus1.out_b), 32'd23);
`endif
            end
        end

        // clr with a valid sample: discarded, outputs hold, valid drops
        step("clr", 1'b1, 1'b1, 1'b0, W'(99), W'(98));
        chk("clr_valid", 32'(bus1.out_valid), 32'd0);

        // restarted stream with a 3-cycle stall after k=2
        for (int k = 0; k < 3; k++) begin
            step("t3", 1'b1, 1'b0, 1'b0, W'(10 + k), W'(20 + k));
            if (k < 2) chk("t3_postclr_valid", 32'(bus1.out_valid), 32'd0);
        end
`ifndef OUTCOMM_EXT_SEL_EN
        chk("t3_k2_a", 32'(bus1.out_a), 32'd20);
        chk("t3_k2_b", 32'(bus1.out_b), 32'd21);
`endif
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b0, 1'b0, W'($urandom), W'($urandom));
            chk("stall_valid", 32'(bus1.out_valid), 32'd0);
`ifndef OUTCOMM_EXT_SEL_EN
            chk("stall_a", 32'(bus1.out_a), 32'd20);
            chk("stall_b", 32'(bus1.out_b), 32'd21);
`endif
        end
        step("t3", 1'b1, 1'b0, 1'b0, W'(13), W'(23));
`ifndef OUTCOMM_EXT_SEL_EN
        chk("resume_a", 32'(bus1.out_a), 32'd12);
        chk("resume_b", 32'(bus1.out_b), 32'd13);
`endif
        chk("resume_valid", 32'(bus1.out_valid), 32'd1);

        // DEPTH=4 fill: valid stays low for 8 accepted samples, rises after the 9th
        step("d4clr", 1'b0, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 12; k++) begin
            step("d4", 1'b1, 1'b0, 1'($urandom_range(1)), W'($urandom), W'($urandom));
            chk("d4_fill_valid", 32'(bus4.out_valid), (k >= 8) ? 32'd1 : 32'd0);
        end

        // randomized stream with stalls and occasional clr
        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(3) != 0);
            rc = ($urandom_range(24) == 0);
            rs = 1'($urandom_range(1));
            r1 = W'($urandom);
            r2 = W'($urandom);
            step("rand", rv, rc, rs, r1, r2);
        end

        // asynchronous reset pulse between edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_a", 32'(bus1.out_a), 32'd0);
        chk("arst_b", 32'(bus1.out_b), 32'd0);
        chk("arst_v", 32'(bus1.out_valid), 32'd0);
        chk("arst_d4_a", 32'(bus4.out_a), 32'd0);
        chk("arst_d4_b", 32'(bus4.out_b), 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step("post_rst", 1'b1, 1'b0, 1'($urandom_range(1)), W'($urandom), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
